// File: rtl/regdst_pkg.sv
// Shared opcode constants and destination-select encodings for the regdst decode stage.
package regdst_pkg;

  typedef enum logic [1:0] {
    SEL_RD   = 2'b00,
    SEL_RT   = 2'b01,
    SEL_RS   = 2'b10,
    SEL_LINK = 2'b11
  } sel_e;

  localparam logic [4:0] OP_HALT  = 5'b00000;
  localparam logic [4:0] OP_NOP   = 5'b00001;
  localparam logic [4:0] OP_J     = 5'b00100;
  localparam logic [4:0] OP_JAL   = 5'b00110;
  localparam logic [4:0] OP_JALR  = 5'b00111;
  localparam logic [4:0] OP_I1_LO = 5'b01000;
  localparam logic [4:0] OP_I1_HI = 5'b01011;
  localparam logic [4:0] OP_ST    = 5'b10000;
  localparam logic [4:0] OP_LD    = 5'b10001;
  localparam logic [4:0] OP_SLBI  = 5'b10010;
  localparam logic [4:0] OP_STU   = 5'b10011;
  localparam logic [4:0] OP_I2_LO = 5'b10100;
  localparam logic [4:0] OP_I2_HI = 5'b10111;
  localparam logic [4:0] OP_LBI   = 5'b11000;
  localparam logic [4:0] OP_BTR   = 5'b11001;
  localparam logic [4:0] OP_ROL   = 5'b11010;
  localparam logic [4:0] OP_ADD   = 5'b11011;
  localparam logic [4:0] OP_SEQ   = 5'b11100;
  localparam logic [4:0] OP_SCO   = 5'b11111;

endpackage

// File: rtl/regdst_decode.sv
// Combinational opcode decode: destination select, write enable and source usage.
module regdst_decode
  import regdst_pkg::*;
(
  input  logic [4:0] opcode,
  output logic [1:0] sel,
  output logic       we,
  output logic       uses_rs,
  output logic       uses_rt
);

  always_comb begin
    sel = SEL_RD;
    we  = 1'b0;
    case (opcode) inside
      OP_BTR, OP_ROL, OP_ADD, [OP_SEQ:OP_SCO]: we = 1'b1;
      [OP_I1_LO:OP_I1_HI], [OP_I2_LO:OP_I2_HI], OP_LD: begin
        sel = SEL_RT;
        we  = 1'b1;
      end
      OP_LBI, OP_SLBI, OP_STU: begin
        sel = SEL_RS;
        we  = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        sel = SEL_LINK;
        we  = 1'b1;
      end
      default: ;
    endcase
  end

  assign uses_rs = !(opcode inside {OP_HALT, OP_NOP, OP_J, OP_JAL, OP_LBI});
  assign uses_rt = opcode inside {OP_ROL, OP_ADD, [OP_SEQ:OP_SCO], OP_ST, OP_STU};

endmodule

// File: rtl/regdst_stage.sv
// Registered destination-register decode stage with valid/ready handshake.
// Optional RAW scoreboard enabled by defining REGDST_SCOREBOARD_EN.
module regdst_stage
  import regdst_pkg::*;
#(
  parameter int unsigned REG_W    = 3,
  parameter int unsigned LINK_REG = 7,
  parameter int unsigned CNT_W    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_instr,
  output logic [1:0]       out_sel,
  output logic [REG_W-1:0] out_dst,
  output logic             out_we,
  input  logic             retire_valid,
  input  logic [REG_W-1:0] retire_idx,
  output logic             sb_err
);

  logic [1:0]       dec_sel;
  logic             dec_we;
  logic             dec_uses_rs;
  logic             dec_uses_rt;
  logic [REG_W-1:0] rs_idx;
  logic [REG_W-1:0] rt_idx;
  logic [REG_W-1:0] rd_idx;
  logic [REG_W-1:0] dst;
  logic             stall;
  logic             load;

  regdst_decode u_decode (
    .opcode  (instr[15:11]),
    .sel     (dec_sel),
    .we      (dec_we),
    .uses_rs (dec_uses_rs),
    .uses_rt (dec_uses_rt)
  );

  assign rs_idx = REG_W'(instr[10:8]);
  assign rt_idx = REG_W'(instr[7:5]);
  assign rd_idx = REG_W'(instr[4:2]);

  always_comb begin
    dst = rd_idx;
    case (dec_sel)
      SEL_RT:   dst = rt_idx;
      SEL_RS:   dst = rs_idx;
      SEL_LINK: dst = REG_W'(LINK_REG);
      default:  dst = rd_idx;
    endcase
  end

  assign in_ready = !rst && !flush && !stall && (!out_valid || out_ready);
  assign load     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_sel   <= '0;
      out_dst   <= '0;
      out_we    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_instr <= instr;
      out_sel   <= dec_sel;
      out_dst   <= dst;
      out_we    <= dec_we;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef REGDST_SCOREBOARD_EN
  localparam int unsigned    NREG    = 1 << REG_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt [NREG];
  logic             inc;
  logic             cancel;
  logic             rs_hit;
  logic             rt_hit;

  assign inc    = out_valid && out_ready && out_we;
  // A write issuing and a retire landing on the same register net to zero.
  assign cancel = inc && retire_valid && (out_dst == retire_idx);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cnt <= '{default: '0};
    end else if (!cancel) begin
      if (inc && cnt[out_dst] != CNT_MAX)
        cnt[out_dst] <= cnt[out_dst] + 1'b1;
      if (retire_valid && cnt[retire_idx] != '0)
        cnt[retire_idx] <= cnt[retire_idx] - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      sb_err <= 1'b0;
    else if (!flush && retire_valid && !cancel && cnt[retire_idx] == '0)
      sb_err <= 1'b1;
  end

  assign rs_hit = dec_uses_rs &&
                  (cnt[rs_idx] != '0 || (out_valid && out_we && out_dst == rs_idx));
  assign rt_hit = dec_uses_rt &&
                  (cnt[rt_idx] != '0 || (out_valid && out_we && out_dst == rt_idx));
  assign stall  = rs_hit || rt_hit || (cnt[dst] == CNT_MAX);
`else
  logic unused_sb;
  assign unused_sb = ^{retire_valid, retire_idx, dec_uses_rs, dec_uses_rt};
  assign stall     = 1'b0;
  assign sb_err    = 1'b0;
`endif

endmodule

// File: tb/tb_regdst_stage.sv
// Self-checking bench for regdst_stage: decode table, handshake/scoreboard sequences, random vs model.
module tb_regdst_stage;

`ifdef REGDST_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_we;
  logic        retire_valid, sb_err;
  logic [15:0] instr, out_instr;
  logic [1:0]  out_sel;
  logic [2:0]  out_dst, retire_idx;

  int n_checks = 0;
  int n_fail   = 0;

  regdst_stage #(.REG_W(3), .LINK_REG(7), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_sel(out_sel), .out_dst(out_dst), .out_we(out_we), .retire_valid(retire_valid),
    .retire_idx(retire_idx), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] in;
    int          sel;
    int          dst;
    bit          we;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    retire_valid = 1'b0; retire_idx = '0; instr = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    #1 chk("in_ready during reset", in_ready, 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Reference decode written straight from the opcode lists.
  function automatic void ref_dec(input logic [15:0] i, output int sel, output int dst,
                                  output bit we, output bit urs, output bit urt);
    int op;
    op = int'(i[15:11]);
    sel = 0;
    we  = 0;
    if (op == 25 || op == 27 || op == 26 || op >= 28) we = 1;
    else if ((op >= 8 && op <= 11) || (op >= 20 && op <= 23) || op == 17) begin sel = 1; we = 1; end
    else if (op == 24 || op == 18 || op == 19) begin sel = 2; we = 1; end
    else if (op == 6 || op == 7) begin sel = 3; we = 1; end
    case (sel)
      0: dst = int'(i[4:2]);
      1: dst = int'(i[7:5]);
      2: dst = int'(i[10:8]);
      default: dst = 7;
    endcase
    urs = !(op == 0 || op == 1 || op == 4 || op == 6 || op == 24);
    urt = (op == 27 || op == 26 || op >= 28 || op == 16 || op == 19);
  endfunction

  vec_t vecs[10];

  initial begin
    bit          mv, mwe, merr;
    int          msel, mdst;
    logic [15:0] minstr;
    int          cnt[8];

    vecs[0] = '{16'hD8E4, 0, 1, 1'b1};  // ADD
    vecs[1] = '{16'h3A00, 3, 7, 1'b1};  // JALR
    vecs[2] = '{16'h8000, 0, 0, 1'b0};  // ST
    vecs[3] = '{16'h41A8, 1, 5, 1'b1};
    vecs[4] = '{16'hC600, 2, 6, 1'b1};  // LBI
    vecs[5] = '{16'h0000, 0, 0, 1'b0};  // HALT
    vecs[6] = '{16'h887C, 1, 3, 1'b1};  // LD
    vecs[7] = '{16'hFA98, 0, 6, 1'b1};
    vecs[8] = '{16'h3000, 3, 7, 1'b1};  // JAL
    vecs[9] = '{16'h9D00, 2, 5, 1'b1};  // STU

    do_reset();
    chk("reset out_valid", out_valid, 0);
    chk("reset out_instr", out_instr, 0);
    chk("reset out_sel", out_sel, 0);
    chk("reset out_dst", out_dst, 0);
    chk("reset out_we", out_we, 0);
    chk("reset sb_err", sb_err, 0);

    foreach (vecs[k]) begin
      do_reset();
      in_valid = 1'b1; instr = vecs[k].in; out_ready = 1'b1;
      #1 chk("table in_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk("table out_valid", out_valid, 1);
      chk("table out_instr", out_instr, vecs[k].in);
      chk("table out_sel", out_sel, vecs[k].sel);
      chk("table out_dst", out_dst, vecs[k].dst);
      chk("table out_we", out_we, vecs[k].we);
    end

    // Backpressure: hold for three cycles, then drain one per cycle.
    do_reset();
    in_valid = 1'b1; instr = 16'h8000; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; instr = 16'h8004;
    for (int j = 0; j < 3; j++) begin
      #1 chk("hold in_ready", in_ready, 0);
      tick();
      chk("hold out_valid", out_valid, 1);
      chk("hold out_instr", out_instr, 16'h8000);
    end
    out_ready = 1'b1;
    #1 chk("release in_ready", in_ready, 1);
    tick();
    chk("drain1 out_instr", out_instr, 16'h8004);
    instr = 16'h8008;
    #1 chk("drain2 in_ready", in_ready, 1);
    tick();
    chk("drain2 out_instr", out_instr, 16'h8008);
    in_valid = 1'b0;
    tick();
    chk("drained out_valid", out_valid, 0);

`ifdef REGDST_SCOREBOARD_EN
    // RAW on r2: stalled until the retire, accepted the cycle after it.
    do_reset();
    in_valid = 1'b1; instr = 16'h4040; out_ready = 1'b1;
    tick();
    instr = 16'hDA04;
    #1 chk("raw held in_ready", in_ready, 0);
    tick();
    chk("raw out_valid", out_valid, 0);
    repeat (2) begin
      #1 chk("raw pending in_ready", in_ready, 0);
      tick();
    end
    retire_valid = 1'b1; retire_idx = 3'd2;
    #1 chk("raw retire cycle in_ready", in_ready, 0);
    tick();
    retire_valid = 1'b0;
    #1 chk("raw after retire in_ready", in_ready, 1);
    tick();
    chk("raw accepted out_valid", out_valid, 1);
    chk("raw accepted out_instr", out_instr, 16'hDA04);
    in_valid = 1'b0;

    // Same-cycle increment and retire on r3 leaves count at 1.
    do_reset();
    in_valid = 1'b1; instr = 16'h4060; out_ready = 1'b1;
    tick();
    #1 chk("r3 second write in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0; retire_valid = 1'b1; retire_idx = 3'd3;
    tick();
    retire_valid = 1'b0; in_valid = 1'b1; instr = 16'hDB04;
    #1 chk("r3 count kept in_ready", in_ready, 0);
    tick();
    retire_valid = 1'b1; retire_idx = 3'd3;
    #1 chk("r3 last retire in_ready", in_ready, 0);
    tick();
    retire_valid = 1'b0;
    #1 chk("r3 cleared in_ready", in_ready, 1);
    chk("r3 no sb_err", sb_err, 0);
    tick();
    in_valid = 1'b0;

    do_reset();
    retire_valid = 1'b1; retire_idx = 3'd5;
    tick();
    retire_valid = 1'b0;
    chk("sb_err set", sb_err, 1);
    tick(); tick();
    chk("sb_err sticky", sb_err, 1);
`else
    do_reset();
    in_valid = 1'b1; instr = 16'h4040; out_ready = 1'b1;
    tick();
    instr = 16'hDA04;
    #1 chk("no-sb in_ready", in_ready, 1);
    tick();
    chk("no-sb out_instr", out_instr, 16'hDA04);
    in_valid = 1'b0; retire_valid = 1'b1; retire_idx = 3'd5;
    tick();
    retire_valid = 1'b0;
    chk("no-sb sb_err", sb_err, 0);
`endif

    // Flush with a held entry, a pending write on r2 and a retire.
    in_valid = 1'b1; instr = 16'h4040; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1; instr = 16'h8000; out_ready = 1'b0;
    tick();
    flush = 1'b1; instr = 16'h8004; out_ready = 1'b1;
    retire_valid = 1'b1; retire_idx = 3'd5;
    #1 chk("flush in_ready", in_ready, 0);
    tick();
    flush = 1'b0; retire_valid = 1'b0;
    chk("flush out_valid", out_valid, 0);
    chk("flush keeps sb_err", sb_err, SB);
    instr = 16'hDA04;
    #1 chk("flush cleared counters", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("post-flush out_instr", out_instr, 16'hDA04);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst clears sb_err", sb_err, 0);
    chk("rst clears out_valid", out_valid, 0);

    // Random traffic against a cycle-level model.
    do_reset();
    mv = 0; mwe = 0; merr = 0; msel = 0; mdst = 0; minstr = '0;
    foreach (cnt[r]) cnt[r] = 0;
    for (int c = 0; c < 500; c++) begin
      int  sel, dst, rs, rt, s, rix;
      bit  we, urs, urt, stall, exp_ready, inc, load;
      flush        = ($urandom % 25) == 0;
      in_valid     = ($urandom % 4) != 0;
      instr        = 16'($urandom);
      out_ready    = ($urandom % 3) != 0;
      retire_valid = ($urandom % 3) == 0;
      s = int'($urandom % 8);
      rix = s;
      for (int q = 0; q < 8; q++) begin
        if (cnt[(s + q) % 8] > 0) begin
          rix = (s + q) % 8;
          break;
        end
      end
      retire_idx = 3'(rix);
      ref_dec(instr, sel, dst, we, urs, urt);
      rs = int'(instr[10:8]);
      rt = int'(instr[7:5]);
      stall = SB && ((urs && (cnt[rs] != 0 || (mv && mwe && mdst == rs))) ||
                     (urt && (cnt[rt] != 0 || (mv && mwe && mdst == rt))) ||
                     cnt[dst] == 3);
      exp_ready = !flush && !stall && (!mv || out_ready);
      #1 chk("rand in_ready", in_ready, exp_ready);
      tick();
      load = in_valid && exp_ready;
      inc  = mv && out_ready && mwe;
      if (flush) begin
        foreach (cnt[r]) cnt[r] = 0;
        mv = 0;
      end else begin
        if (SB && !(inc && retire_valid && mdst == rix)) begin
          if (retire_valid) begin
            if (cnt[rix] == 0) merr = 1;
            else cnt[rix]--;
          end
          if (inc && cnt[mdst] < 3) cnt[mdst]++;
        end
        if (load) begin
          mv = 1; minstr = instr; msel = sel; mdst = dst; mwe = we;
        end else if (out_ready) begin
          mv = 0;
        end
      end
      chk("rand out_valid", out_valid, mv);
      chk("rand sb_err", sb_err, merr);
      if (mv) begin
        chk("rand out_instr", out_instr, minstr);
        chk("rand out_sel", out_sel, msel);
        chk("rand out_dst", out_dst, mdst);
        chk("rand out_we", out_we, mwe);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regdst_stage.md
# regdst_stage

Registered decode stage that turns a 16-bit WISC instruction into a destination-register select, an index and a write enable. It replaces the single-cycle destination mux with a stage that has a valid/ready handshake and a one-entry output register. An optional per-register scoreboard stalls read-after-write hazards. It sits between fetch and the register-file read in the pipelined processor.

## Interface
- `REG_W`, 3: register index width; register file has 2^REG_W entries.
- `LINK_REG`, 7: index written by JAL/JALR.
- `CNT_W`, 2: pending-write counter width per register; maximum outstanding writes per register is 2^CNT_W−1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  squash the held entry and clear the scoreboard.
- `in_valid`  in  1  `instr` is valid.
- `in_ready`  out  1  stage accepts `instr` this cycle (combinational).
- `instr`  in  16  instruction; opcode is [15:11], Rs is [10:8], Rt is [7:5], Rd is [4:2].
- `out_valid`  out  1  held entry is valid.
- `out_ready`  in  1  downstream accepts the held entry.
- `out_instr`  out  16  held instruction.
- `out_sel`  out  2  destination select: 00=Rd, 01=Rt, 10=Rs, 11=link.
- `out_dst`  out  REG_W  resolved destination index.
- `out_we`  out  1  register write enable.
- `retire_valid`  in  1  a write to `retire_idx` completed downstream.
- `retire_idx`  in  REG_W  register being retired.
- `sb_err`  out  1  sticky flag: retire was seen on a register whose counter is zero.

## Operation
- Decode table for opcode [15:11]. Any opcode not listed gives sel=00, we=0.
  - sel=00, we=1: 11001, 11011, 11010, 11100–11111.
  - sel=01, we=1: 01000–01011, 10100–10111, 10001.
  - sel=10, we=1: 11000, 10010, 10011.
  - sel=11, we=1: 00110, 00111. `out_dst` is forced to `LINK_REG`.
- The Rs source is used by every opcode except 00000, 00001, 00100, 00110 and 11000.
- The Rt source is used by 11011, 11010, 11100–11111, 10000 and 10011.
- Output register:
  - Loads on `in_valid && in_ready`.
  - Holds while `out_valid && !out_ready`.
  - Clears `out_valid` when drained with no new load.
- `in_ready = !flush && !stall && (!out_valid || out_ready)`.
- Scoreboard (macro enabled):
  - One CNT_W counter per register.
  - Increment `cnt[out_dst]` on `out_valid && out_ready && out_we`.
  - Decrement `cnt[retire_idx]` on `retire_valid`.
  - If both events hit the same register in one cycle, its count is unchanged.
- `stall` is set when any of the following holds:
  - A used source has a nonzero count.
  - A used source equals the held `out_dst`, with `out_valid && out_we`.
  - The incoming destination's count is at its maximum.
- A retire on a zero counter leaves the counter at 0 and sets `sb_err`. `sb_err` is cleared only by `rst`.
- `flush` behaviour:
  - Next cycle: `out_valid`=0 and all counters are 0.
  - Overrides any same-cycle load, drain or retire.
  - `sb_err` is kept.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is on `out_*` after edge N.
- Full throughput (one instruction per cycle) when `out_ready` is held at 1 and there is no stall.
- Reset: `out_valid`, `out_instr`, `out_sel`, `out_dst`, `out_we`, all counters and `sb_err` are 0. `in_ready` is low in the reset cycle.
- `out_*` data is stable while `out_valid && !out_ready`.
- A retire in cycle N clears a stall in cycle N+1, not in the same cycle.
- A mid-operation `rst` behaves exactly like power-on reset and overrides `flush`.

## Configuration
- `REGDST_SCOREBOARD_EN` defined: scoreboard, stall logic and `sb_err` are as described above.
- Not defined:
  - No counters are built and `stall` is 0.
  - `retire_*` inputs are ignored.
  - `sb_err` is tied to 0.
  - The stage is a plain one-entry registered decoder.

## Structure
- Package `regdst_pkg` holds:
  - Opcode localparams.
  - Select encodings `SEL_RD`, `SEL_RT`, `SEL_RS`, `SEL_LINK`.
- Sub-module `regdst_decode`: purely combinational; opcode → sel, we, uses_rs, uses_rt.
- `regdst_stage` holds the output register, the handshake and the scoreboard.

## Test plan
- Reset, then ADD 0xD8E4 (11011, Rs=0, Rt=7, Rd=1) with `out_ready`=1 → after 1 cycle: sel=00, dst=1, we=1.
- JALR 0x3A00 → sel=11, dst=7, we=1. ST 0x8000 → we=0, sel=00.
- `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0, `out_instr` held; releasing `out_ready` drains one instruction per cycle.
- Scoreboard build: ADDI writing r2 drained, then an instruction reading r2 → stall until `retire_idx`=2, accepted one cycle after the retire.
- Scoreboard build: retire r5 with cnt=0 → `sb_err`=1, which persists until `rst`. A same-cycle increment and decrement on r3 leaves the count unchanged.
- `flush` together with `in_valid` and `retire_valid` → next cycle: `out_valid`=0, counters 0, instruction not accepted.
